// File: rtl/boot_rom_arbiter.sv
// Round-robin read arbiter sharing the boot ROM port between instruction fetch (m0) and data (m1).
// Define ROMARB_TIMEOUT_EN to add the DATA-phase watchdog and its TOUT response state.
module boot_rom_arbiter #(
    parameter int                 DATA_W         = 32,
    parameter int                 TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA   = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [31:0]       m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [31:0]       s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,
    output logic              s_rready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
`ifdef ROMARB_TIMEOUT_EN
        , ST_TOUT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_owner;
    logic        r_last;
    logic        w_grant;
    logic        w_win;
    logic        w_own_rready;

`ifdef ROMARB_TIMEOUT_EN
    logic [7:0]  r_timer;
    logic        r_tout_seen;
    logic        w_unused_dbg;
    // Sticky debug flag has no port; it is only probed hierarchically.
    assign w_unused_dbg = r_tout_seen;
`else
    logic        w_unused_params;
    assign w_unused_params = ^{TIMEOUT_DATA, TIMEOUT_CYCLES[7:0]};
`endif

    assign w_own_rready = r_owner ? m1_rready : m0_rready;
    // On a tie the requester that did not win last time gets the port.
    assign w_win = (m0_arvalid && m1_arvalid) ? ~r_last : m1_arvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
`ifdef ROMARB_TIMEOUT_EN
            r_timer     <= '0;
            r_tout_seen <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_addr  <= w_win ? m1_araddr : m0_araddr;
                r_owner <= w_win;
                r_last  <= w_win;
            end
`ifdef ROMARB_TIMEOUT_EN
            if (r_state == ST_ADDR && s_arready)
                r_timer <= '0;
            else if (r_state == ST_DATA && !s_rvalid)
                r_timer <= r_timer + 8'd1;
            if (r_state == ST_TOUT && w_own_rready)
                r_tout_seen <= 1'b1;
`endif
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        s_arvalid  = 1'b0;
        s_araddr   = r_addr;
        s_rready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Always ready here so a stale beat left over from a reset is drained.
                s_rready = 1'b1;
                if (m0_arvalid || m1_arvalid) begin
                    w_grant    = 1'b1;
                    m0_arready = ~w_win;
                    m1_arready = w_win;
                    w_next     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready)
                    w_next = ST_DATA;
            end
            ST_DATA: begin
                s_rready = w_own_rready;
                if (r_owner) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rvalid ? s_rdata : '0;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rvalid ? s_rdata : '0;
                end
                if (s_rvalid && w_own_rready)
                    w_next = ST_IDLE;
`ifdef ROMARB_TIMEOUT_EN
                else if (!s_rvalid && r_timer == 8'(TIMEOUT_CYCLES - 1))
                    w_next = ST_TOUT;
`endif
            end
`ifdef ROMARB_TIMEOUT_EN
            ST_TOUT: begin
                if (r_owner) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = TIMEOUT_DATA;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = TIMEOUT_DATA;
                end
                if (w_own_rready)
                    w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
